kuznechik_round_ctrl: RTL

- Sequencer between a plaintext stream and the kuznechik_encrypt core.
- Holds the 10 round keys in an internal key table and starts the core once per block.
- Answers each core key_next request with the next round key, and captures the ciphertext into a one-entry output buffer with a valid/ready handshake.
- Detects protocol violations and core hangs.

---
 rtl/kuznechik_round_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/kuznechik_round_ctrl.sv
// Round sequencer for a kuznechik_encrypt core: holds the round-key table, feeds keys on request,
// buffers one ciphertext with a valid/ready handshake and flags protocol errors or core hangs.
module kuznechik_round_ctrl #(
    parameter int NUM_KEYS = 10,
    parameter int DATA_W   = 128,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              key_wr_en_i,
    input  logic [3:0]        key_wr_addr_i,
    input  logic [DATA_W-1:0] key_wr_data_i,
    output logic              key_wr_err_o,
    output logic              keys_loaded_o,

    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,

    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,

    output logic              core_en_o,
    output logic [DATA_W-1:0] core_in_data_o,
    output logic [DATA_W-1:0] core_round_key_o,
    output logic              core_key_valid_o,
    input  logic              core_key_next_i,
    input  logic [DATA_W-1:0] core_out_data_i,
    input  logic              core_ready_i,

    output logic              busy_o,
    output logic              err_seq_o,
    output logic [CNT_W-1:0]  blk_count_o
);

    localparam int IDX_W = $clog2(NUM_KEYS + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_DONE   = IDX_W'(NUM_KEYS);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]       ADDR_LIMIT = 4'(NUM_KEYS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e              state_q;
    logic [NUM_KEYS-1:0] loadedMask_q;
    logic [DATA_W-1:0]   keyMem_q [NUM_KEYS];
    logic [IDX_W-1:0]    keyIdx_q;
    logic [WD_W-1:0]     wdog_q;
    logic                coreEn_q;
    logic [DATA_W-1:0]   coreInData_q;
    logic [DATA_W-1:0]   roundKey_q;
    logic                keyValid_q;
    logic [DATA_W-1:0]   mData_q;
    logic                mValid_q;
    logic [CNT_W-1:0]    blkCount_q;
    logic                errSeq_q;
    logic                keyWrErr_q;

    logic                isIdle;
    logic                keysLoaded;
    logic                keyWrOk;
    logic                sFire;
    logic [NUM_KEYS-1:0] wrSel;

    assign isIdle     = (state_q == IDLE);
    assign keysLoaded = &loadedMask_q;
    assign keyWrOk    = key_wr_en_i && isIdle && (key_wr_addr_i < ADDR_LIMIT);
    assign sFire      = s_valid_i && isIdle && keysLoaded;
    assign wrSel      = NUM_KEYS'(1) << key_wr_addr_i;

    // Key storage carries no reset; the loaded mask alone decides whether its contents are usable.
    always_ff @(posedge clk_i) begin
        if (keyWrOk) begin
            keyMem_q[key_wr_addr_i] <= key_wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            loadedMask_q <= '0;
            keyIdx_q     <= '0;
            wdog_q       <= '0;
            coreEn_q     <= 1'b0;
            coreInData_q <= '0;
            roundKey_q   <= '0;
            keyValid_q   <= 1'b0;
            mData_q      <= '0;
            mValid_q     <= 1'b0;
            blkCount_q   <= '0;
            errSeq_q     <= 1'b0;
            keyWrErr_q   <= 1'b0;
        end else begin
            keyValid_q <= 1'b0;
            errSeq_q   <= 1'b0;
            keyWrErr_q <= key_wr_en_i && !keyWrOk;

            if (keyWrOk) begin
                loadedMask_q <= loadedMask_q | wrSel;
            end

            case (state_q)
                IDLE: begin
                    if (sFire) begin
                        coreInData_q <= s_data_i;
                        coreEn_q     <= 1'b1;
                        keyIdx_q     <= '0;
                        wdog_q       <= '0;
                        state_q      <= RUN;
                    end
                end

                // A result wins over a simultaneous key request, which is then dropped.
                RUN: begin
                    if (core_ready_i) begin
                        coreEn_q <= 1'b0;
                        wdog_q   <= '0;
                        if (keyIdx_q == IDX_DONE) begin
                            mData_q    <= core_out_data_i;
                            mValid_q   <= 1'b1;
                            blkCount_q <= blkCount_q + CNT_W'(1);
                            state_q    <= OUT;
                        end else begin
                            errSeq_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end else if (core_key_next_i) begin
                        wdog_q <= '0;
                        if (keyIdx_q < IDX_DONE) begin
                            roundKey_q <= keyMem_q[keyIdx_q];
                            keyValid_q <= 1'b1;
                            keyIdx_q   <= keyIdx_q + IDX_W'(1);
                        end else begin
                            errSeq_q <= 1'b1;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        errSeq_q <= 1'b1;
                        coreEn_q <= 1'b0;
                        wdog_q   <= '0;
                        state_q  <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end

                OUT: begin
                    if (m_ready_i) begin
                        mValid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                default: begin
                    coreEn_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign key_wr_err_o     = keyWrErr_q;
    assign keys_loaded_o    = keysLoaded;
    assign s_ready_o        = isIdle && keysLoaded;
    assign m_valid_o        = mValid_q;
    assign m_data_o         = mData_q;
    assign core_en_o        = coreEn_q;
    assign core_in_data_o   = coreInData_q;
    assign core_round_key_o = roundKey_q;
    assign core_key_valid_o = keyValid_q;
    assign busy_o           = !isIdle;
    assign err_seq_o        = errSeq_q;
    assign blk_count_o      = blkCount_q;

endmodule
